trace_config_sequencer: RTL
===========================

// Module: trace_config_sequencer
// PURPOSE
// Sequences reconfiguration of the trace pipeline: buffers host config writes and gates new enqueues into the input buffer.
// Waits for the pipeline to drain, then drops tracing and broadcasts each (configId, configData) pair once.
// Returns to tracing afterwards. Sits between the host/firmware config port and every block's tracing/configId/configData inputs.
// PARAMETERS
// CMD_DEPTH     4   command FIFO entries (power of 2, >=2)
// DRAIN_CYCLES  8   consecutive quiet cycles required before tracing is dropped (>=1)
// IDLE_ID       8'hFF  configId driven when no write is active; no block may use it as PERSONAL_CONFIG_ID
// PORTS
// clk          in   1  clock
// rst          in   1  synchronous reset, active-high
// cmd_valid    in   1  host command valid
// cmd_ready    out  1  FIFO can accept (= !full)
// cmd_id       in   8  target PERSONAL_CONFIG_ID
// cmd_data     in   8  config value
// cmd_last     in   1  final command of this reconfiguration batch
// enqueue_in   in   1  upstream enqueue request
// enqueue_out  out  1  enqueue to input buffer (= enqueue_in & state==TRACE), combinational
// pipe_valid   in   1  OR of valid_out along the trace pipeline
// tracing      out  1  registered tracing strobe to all blocks
// configId     out  8  registered config target
// configData   out  8  registered config value
// busy         out  1  state!=TRACE
// cfg_done     out  1  one-cycle pulse when a batch completes
// BEHAVIOUR
// Reset: state=TRACE; tracing=1, configId=IDLE_ID, configData=0, cfg_done=0; FIFO flushed; drain counter=0.
// Reset mid-batch abandons the batch: commands already broadcast stay applied, queued ones are dropped.
// FIFO: push when cmd_valid&cmd_ready. Pop only in APPLY. Push while full is refused even if popping that cycle.
// FIFO stores {last,id,data} (17b). Pointers wrap at CMD_DEPTH. Count is $clog2(CMD_DEPTH)+1 bits.
// FSM:
//  TRACE : tracing=1, configId=IDLE_ID. FIFO non-empty -> DRAIN next cycle; enqueue_out forced 0 from that edge.
//  DRAIN : tracing=1 so the input buffer keeps dequeuing. qcnt++ when pipe_valid==0, else qcnt<=0.
//          When qcnt==DRAIN_CYCLES-1 with pipe_valid==0 -> APPLY; tracing=0 from that edge.
//  APPLY : tracing=0. If FIFO non-empty, pop the head and register configId/configData=head the next cycle (1 write/cycle).
//          If FIFO empty, configId=IDLE_ID and wait (batch stall, no timeout).
//          Popping an entry with last=1 -> SETTLE.
//  SETTLE: one cycle, tracing=0, configId=IDLE_ID, cfg_done=1 -> TRACE (tracing=1 next cycle).
// Latency from popped entry to configId/configData valid: 1 cycle. Each pair is valid for exactly one cycle.
// Every non-IDLE configId cycle has tracing==0.
// Min TRACE->TRACE for a 1-command batch with pipe quiet: 1 + DRAIN_CYCLES + 1 + 1 cycles.
// Commands pushed during DRAIN/APPLY join the current batch until a last=1 entry is popped.
// Entries after it start a new batch from TRACE.
// pipe_valid is ignored outside DRAIN. enqueue_in while busy is dropped (enqueue_out=0), not held.
// TESTING
// T1 reset: rst 1 cycle -> tracing=1, configId=FF, busy=0, cmd_ready=1; enqueue_out follows enqueue_in.
// T2 single write {id=3,data=2,last=1}, pipe quiet -> enqueue_out=0 next cycle; tracing=0 after 8 quiet cycles;
//    configId=3/configData=2 for 1 cycle; cfg_done pulse; tracing=1; 11 cycles total.
// T3 drain restart: pipe_valid=1 at qcnt=5 -> counter clears; tracing stays 1 until 8 further consecutive quiet cycles.
// T4 full FIFO: 5 pushes in TRACE with depth 4 -> cmd_ready=0 after 4th, 5th held.
//    Batch of ids 1,2,3,4(last) broadcast on 4 consecutive cycles, in order.
// T5 stall: push id=1 (last=0) only -> APPLY, configId=1 then FF for 10 cycles, tracing=0.
//    Push id=2 last=1 -> configId=2, SETTLE, TRACE.
// T6 reset in APPLY after 1 of 3 writes -> outputs reset values next cycle, FIFO empty, remaining writes never appear.

Source files
------------

// File: rtl/trace_config_sequencer.sv
// trace_config_sequencer: buffers host config writes, drains the trace
// pipeline, then broadcasts each (configId, configData) pair once with
// tracing dropped before returning the pipeline to tracing.
`timescale 1ns/1ps

module trace_config_sequencer #(
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter logic [7:0]  IDLE_ID      = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_id,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  input  logic       enqueue_in,
  output logic       enqueue_out,
  input  logic       pipe_valid,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       busy,
  output logic       cfg_done
);

  localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned QCNT_W = $clog2(DRAIN_CYCLES + 1);

  // One buffered host command: batch terminator plus the (id, data) pair.
  typedef struct packed {
    logic       last;
    logic [7:0] id;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_TRACE  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_APPLY  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  cmd_t              mem [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  cmd_t              head;
  state_t            state;
  logic [QCNT_W-1:0] qcnt;

  // FIFO status and handshake; a full FIFO refuses a push even on a pop cycle.
  assign full      = (count == CNT_W'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign push      = cmd_valid & ~full;
  assign pop       = (state == ST_APPLY) & ~empty;
  assign head      = mem[rd_ptr];
  assign cmd_ready = ~full;

  // Upstream enqueues pass only while tracing normally; otherwise dropped.
  assign enqueue_out = enqueue_in & (state == ST_TRACE);
  assign busy        = (state != ST_TRACE);

  // Command storage; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{last: cmd_last, id: cmd_id, data: cmd_data};
    end
  end

  // FIFO pointers and occupancy; reset flushes any queued commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Reconfiguration sequencer with registered broadcast outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_TRACE;
      tracing    <= 1'b1;
      configId   <= IDLE_ID;
      configData <= 8'h00;
      cfg_done   <= 1'b0;
      qcnt       <= '0;
    end else begin
      cfg_done <= 1'b0;
      unique case (state)
        ST_TRACE: begin
          tracing  <= 1'b1;
          configId <= IDLE_ID;
          qcnt     <= '0;
          if (!empty) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Any pipeline activity restarts the quiet window.
          if (pipe_valid) begin
            qcnt <= '0;
          end else if (qcnt == QCNT_W'(DRAIN_CYCLES - 1)) begin
            qcnt    <= '0;
            tracing <= 1'b0;
            state   <= ST_APPLY;
          end else begin
            qcnt <= qcnt + QCNT_W'(1);
          end
        end
        ST_APPLY: begin
          // One write per cycle; an empty FIFO stalls the batch indefinitely.
          if (pop) begin
            configId   <= head.id;
            configData <= head.data;
            if (head.last) begin
              cfg_done <= 1'b1;
              state    <= ST_SETTLE;
            end
          end else begin
            configId <= IDLE_ID;
          end
        end
        ST_SETTLE: begin
          configId <= IDLE_ID;
          tracing  <= 1'b1;
          state    <= ST_TRACE;
        end
        default: begin
          state <= ST_TRACE;
        end
      endcase
    end
  end

endmodule
